mem_store_buffer: RTL and testbench

Parametrised successor to the combinational store-alignment logic. It accepts core store requests (address, raw data, one-hot size mode), generates byte-lane strobes and lane-shifted write data, and detects misaligned or illegal sizes. Legal stores are queued in a DEPTH-entry FIFO and drained to the data SRAM through a valid/ready handshake. It sits between the MEM stage and the data SRAM port.

---
 rtl/mem_store_buffer.sv | 161 ++++++++++++++++
 tb/tb_mem_store_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// ============================================================================
// Module      : mem_store_buffer
// Description : Store alignment (byte strobes, lane shift, misalign detect)
//               feeding a DEPTH-entry FIFO drained to the data SRAM.
//               Optional macro STB_MERGE_EN merges same-word stores into
//               the youngest non-head entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_store_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_wdata,
    input  logic [3:0]               st_mode,
    output logic                     st_err,
    output logic [ADDR_W-1:0]        st_err_addr,
    output logic                     sram_req,
    input  logic                     sram_ready,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W/8-1:0]      sram_strb,
    output logic [DATA_W-1:0]        sram_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [c_STRB_W-1:0] r_strb [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_err;
    logic [ADDR_W-1:0]   r_err_addr;

    logic [c_OFF_W-1:0]  w_off;
    logic [ADDR_W-1:0]   w_waddr;
    logic [c_STRB_W-1:0] w_base;
    logic [DATA_W-1:0]   w_mask;
    logic [c_STRB_W-1:0] w_strb;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_illegal;
    logic                w_full;
    logic                w_merge;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    assign w_off   = st_addr[c_OFF_W-1:0];
    assign w_waddr = {st_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};

    always_comb begin
        w_base    = '0;
        w_illegal = 1'b0;
        case (st_mode)
            4'b0001: w_base[0] = 1'b1;
            4'b0010: begin
                w_base[1:0] = '1;
                w_illegal   = w_off[0];
            end
            4'b0100: begin
                w_base[3:0] = '1;
                w_illegal   = |w_off[1:0];
            end
            4'b1000: begin
                w_base    = '1;
                w_illegal = (DATA_W == 32) || (|w_off);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < c_STRB_W; i++) begin
            w_mask[8*i +: 8] = {8{w_base[i]}};
        end
    end

    assign w_strb  = w_base << w_off;
    assign w_wdata = (st_wdata & w_mask) << {w_off, 3'b000};

`ifdef STB_MERGE_EN
    logic [c_PTR_W-1:0] w_young;
    assign w_young = r_wptr - c_PTR_W'(1);
    // Head is never the merge target, so SRAM always sees a stable entry.
    assign w_merge = !w_illegal && (r_count >= c_CNT_W'(2)) &&
                     (r_addr[w_young] == w_waddr);
`else
    assign w_merge = 1'b0;
`endif

    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign st_ready = !w_full || w_merge;
    assign w_accept = st_valid && st_ready;
    assign w_push   = w_accept && !w_illegal && !w_merge;
    assign w_pop    = sram_req && sram_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wptr] <= w_waddr;
                r_strb[r_wptr] <= w_strb;
                r_data[r_wptr] <= w_wdata;
                r_wptr         <= r_wptr + c_PTR_W'(1);
            end
`ifdef STB_MERGE_EN
            if (w_accept && w_merge) begin
                r_strb[w_young] <= r_strb[w_young] | w_strb;
                for (int i = 0; i < c_STRB_W; i++) begin
                    if (w_strb[i]) begin
                        r_data[w_young][8*i +: 8] <= w_wdata[8*i +: 8];
                    end
                end
            end
`endif
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            r_err <= w_accept && w_illegal;
            if (w_accept && w_illegal) begin
                r_err_addr <= st_addr;
            end
        end
    end

    assign sram_req    = (r_count != '0);
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign sram_addr   = sram_req ? r_addr[r_rptr] : '0;
    assign sram_strb   = sram_req ? r_strb[r_rptr] : '0;
    assign sram_wdata  = sram_req ? r_data[r_rptr] : '0;
    assign st_err      = r_err;
    assign st_err_addr = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
// ============================================================================
// Module      : tb_mem_store_buffer
// Description : Scoreboard bench for mem_store_buffer (DATA_W=32, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_mode;
    logic        st_err;
    logic [31:0] st_err_addr;
    logic        sram_req;
    logic        sram_ready;
    logic [31:0] sram_addr;
    logic [3:0]  sram_strb;
    logic [31:0] sram_wdata;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        exp_err      = 1'b0;
    logic [31:0] exp_err_addr = '0;

    mem_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_wdata    (st_wdata),
        .st_mode     (st_mode),
        .st_err      (st_err),
        .st_err_addr (st_err_addr),
        .sram_req    (sram_req),
        .sram_ready  (sram_ready),
        .sram_addr   (sram_addr),
        .sram_strb   (sram_strb),
        .sram_wdata  (sram_wdata),
        .count       (count),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_align(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] m, output bit ok,
                                        output logic [3:0] s, output logic [31:0] w);
        int n;
        int off;
        case (m)
            4'b0001: n = 1;
            4'b0010: n = 2;
            4'b0100: n = 4;
            default: n = 0;
        endcase
        off = int'(a[1:0]);
        ok  = (n != 0) && ((off % ((n == 0) ? 1 : n)) == 0);
        s   = 4'(((1 << n) - 1) << off);
        w   = 32'((64'(d) & ((64'd1 << (8 * n)) - 64'd1)) << (8 * off));
    endfunction

    // Reference model: sampled at negedge, where values equal those at the next posedge.
    always @(negedge clk) begin
        bit          ok;
        logic [3:0]  s;
        logic [31:0] w;
        logic        acc;
        logic        pop;
        logic [31:0] wa;
        if (reset) begin
            q.delete();
            exp_err      = 1'b0;
            exp_err_addr = '0;
        end else begin
            chk("st_err", st_err, exp_err);
            chk("st_err_addr", st_err_addr, exp_err_addr);
            chk("count", count, q.size());
            chk("empty", empty, q.size() == 0);
            chk("sram_req", sram_req, q.size() != 0);
            if (q.size() != 0) begin
                chk("head_addr", sram_addr, q[0].addr);
                chk("head_strb", sram_strb, q[0].strb);
                chk("head_data", sram_wdata, q[0].data);
            end else begin
                chk("idle_data", {sram_addr, sram_strb, sram_wdata[27:0]}, 64'h0);
            end
            model_align(st_addr, st_wdata, st_mode, ok, s, w);
            acc = st_valid && st_ready;
            pop = sram_req && sram_ready;
            wa  = {st_addr[31:2], 2'b00};
            exp_err = acc && !ok;
            if (acc && !ok) exp_err_addr = st_addr;
            if (acc && ok) begin
`ifdef STB_MERGE_EN
                if (q.size() >= 2 && q[$].addr == wa) begin
                    for (int i = 0; i < 4; i++)
                        if (s[i]) q[$].data[8*i +: 8] = w[8*i +: 8];
                    q[$].strb = q[$].strb | s;
                end else
`endif
                begin
                    q.push_back('{addr: wa, strb: s, data: w});
                end
            end
            if (pop) void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_mode  = m;
        n = 0;
        @(negedge clk);
        while (!st_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("store_timeout", 1, 0);
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain(output int cycles);
        sram_ready = 1'b1;
        cycles = 0;
        @(negedge clk);
        while (!empty && cycles < 50) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 50) chk("drain_timeout", 1, 0);
        tick();
        sram_ready = 1'b0;
    endtask

    initial begin
        int nc;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_wdata = '0;
        st_mode = 4'b0001; sram_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_req", sram_req, 0);
        tick();

        // Byte store into empty buffer
        store(32'h1003, 32'hF1F2F3F4, 4'b0001);
        @(negedge clk);
        chk("t1_req", sram_req, 1);
        chk("t1_addr", sram_addr, 32'h1000);
        chk("t1_strb", sram_strb, 4'b1000);
        chk("t1_data", sram_wdata, 32'hF4000000);
        tick();
        drain(nc);

        // Half stores, misaligned and illegal modes
        store(32'h2002, 32'hF1F2F3F4, 4'b0010);
        @(negedge clk);
        chk("t2_strb", sram_strb, 4'b1100);
        chk("t2_data", sram_wdata, 32'hF3F40000);
        tick();
        drain(nc);
        store(32'h2001, 32'hF1F2F3F4, 4'b0010);
        @(negedge clk);
        chk("t2_err", st_err, 1);
        chk("t2_err_addr", st_err_addr, 32'h2001);
        chk("t2_count", count, 0);
        tick();
        @(negedge clk);
        chk("t2_err_pulse", st_err, 0);
        tick();
        store(32'h2000, 32'h12345678, 4'b0011);
        @(negedge clk);
        chk("t2_mode_err", st_err, 1);
        tick();
        store(32'h2004, 32'h12345678, 4'b1000);
        @(negedge clk);
        chk("t2_dword_err", st_err, 1);
        tick();

        // Fill to full, stall, then drain in order
        for (int i = 0; i < 4; i++) store(32'h10 + 4 * i, 32'hA0 + i, 4'b0100);
        @(negedge clk);
        chk("t3_count", count, 4);
        chk("t3_ready", st_ready, 0);
        tick();
        st_valid = 1'b1; st_addr = 32'h20; st_wdata = 32'h55; st_mode = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall", st_ready, 0);
        end
        tick();
        st_valid = 1'b0;
        drain(nc);
        chk("t3_drain_cycles", nc, 4);

        // Simultaneous push and pop at count 2
        store(32'h40, 32'h1, 4'b0100);
        store(32'h44, 32'h2, 4'b0100);
        st_valid = 1'b1; st_addr = 32'h48; st_wdata = 32'h3; st_mode = 4'b0100;
        sram_ready = 1'b1;
        tick();
        st_valid = 1'b0; sram_ready = 1'b0;
        @(negedge clk);
        chk("t4_count", count, 2);
        chk("t4_head", sram_addr, 32'h44);
        tick();
        drain(nc);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) store(32'h80 + 4 * i, 32'h9 + i, 4'b0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_req", sram_req, 0);
        tick();
        store(32'h1003, 32'hF1F2F3F4, 4'b0001);
        @(negedge clk);
        chk("t5_addr", sram_addr, 32'h1000);
        chk("t5_data", sram_wdata, 32'hF4000000);
        tick();
        drain(nc);

        // Same-word stores behind a different head
        store(32'h3000, 32'h11223344, 4'b0100);
        store(32'h3004, 32'hAA, 4'b0001);
        store(32'h3005, 32'hBB, 4'b0001);
        @(negedge clk);
`ifdef STB_MERGE_EN
        chk("t6_count", count, 2);
`else
        chk("t6_count", count, 3);
`endif
        tick();
        sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
        @(negedge clk);
`ifdef STB_MERGE_EN
        chk("t6_strb", sram_strb, 4'b0011);
        chk("t6_data", sram_wdata, 32'h0000BBAA);
`else
        chk("t6_strb", sram_strb, 4'b0001);
        chk("t6_data", sram_wdata, 32'h000000AA);
`endif
        tick();
        drain(nc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
